clock_hand_sequencer: RTL and testbench
=======================================

Name: clock_hand_sequencer

Overview:
- Control FSM that schedules all work for one analog-clock frame: clear the 64x64 framebuffer, then draw the hour, minute, second and alarm hands in order.
- Time-shares one external CORDIC sin/cos unit across the four hands and emits pixel-set requests to the framebuffer write port over a valid/ready handshake.
- Sits between the time/alarm counters and the framebuffer/VGA scan-out logic.

Parameters:
- CENTER, 32: framebuffer centre coordinate, used for both x and y.
- HOUR_LEN, 23: maximum radius of the hour hand.
- MIN_LEN, 31: maximum radius of the minute hand.
- SEC_LEN, 27: maximum radius of the second hand.
- ALARM_LEN, 17: maximum radius of the alarm hand.
- STEP, 2: radius increment between plotted points.
- CORDIC_TIMEOUT, 63: number of cycles to wait for cordic_done before abandoning a hand.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_req  in  1  frame trigger; only its rising edge is used
- hour_angle  in  9  degrees, 0-359
- minute_angle  in  9  degrees, 0-359
- second_angle  in  9  degrees, 0-359
- alarm_angle  in  9  degrees, 0-359
- alarm_en  in  1  draw the alarm hand when 1
- cordic_start  out  1  one-cycle start pulse to the CORDIC
- cordic_angle  out  16  angle to the CORDIC: snapshot angle, zero-extended
- cordic_sin  in  16  signed Q2.14 result (16384 = +1.0)
- cordic_cos  in  16  signed Q2.14 result
- cordic_done  in  1  result-valid pulse from the CORDIC
- clr_valid  out  1  row-clear request
- clr_row  out  6  row index to clear
- wr_valid  out  1  pixel-set request
- wr_x  out  6  pixel column
- wr_y  out  6  pixel row
- fb_ready  in  1  framebuffer accepts a clr or wr request this cycle
- busy  out  1  high from the start of CLEAR through DONE
- frame_done  out  1  one-cycle pulse when a frame completes
- err_timeout  out  1  sticky CORDIC-timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, pending flag 0, err_timeout 0.
  - Applies asynchronously at any point, including mid-frame.
  - No request may be issued after reset asserts.
- Edge detect: frame_req is registered. A rising edge is a cycle where frame_req=1 and the registered copy=0.
- States:
  - IDLE -> CLEAR -> per hand {CREQ -> CWAIT -> PLOT} -> NEXT -> ... -> DONE -> IDLE.
- IDLE:
  - On a rising edge, snapshot all four angles and alarm_en.
  - Next cycle: enter CLEAR with busy=1 and clr_row=0.
- CLEAR:
  - clr_valid=1.
  - clr_row increments by 1 on each clr_valid&&fb_ready.
  - Acceptance of row 63 leads to CREQ for the hour hand.
- CREQ:
  - cordic_start=1 for exactly one cycle; cordic_angle = snapshot angle.
  - Next state is CWAIT; the timeout counter is cleared.
- CWAIT:
  - cordic_done is sampled only in this state and ignored in every other state.
  - On cordic_done: latch sin and cos, set r=1, go to PLOT.
  - Otherwise the counter increments each cycle. When it reaches CORDIC_TIMEOUT, set err_timeout=1 and go to NEXT; that hand is skipped.
- PLOT arithmetic:
  - ps = sin*r and pc = cos*r, signed, at least 22 bits.
  - so = ps/16384 and co = pc/16384, truncating toward zero: a negative value v gives -((-v)>>14).
  - x = CENTER+so, y = CENTER-co, each computed as signed 8-bit.
- PLOT sequencing:
  - If 0<=x<=63 and 0<=y<=63: wr_valid=1 with wr_x=x, wr_y=y. These values stay stable until fb_ready.
  - Otherwise the point is skipped: no wr_valid, and r advances in the same cycle.
  - After a point is accepted or skipped: if r+STEP > LEN go to NEXT, else r += STEP.
  - wr_x and wr_y may be combinational from registered r and the latched sin/cos.
- NEXT:
  - Hand order is hour, minute, second, alarm.
  - The alarm hand is skipped when the alarm_en snapshot is 0.
  - After the last hand, go to DONE.
- DONE:
  - frame_done=1 for one cycle.
  - If pending=1: clear pending, take a new snapshot, go to CLEAR with busy held at 1.
  - Else: go to IDLE with busy=0.
- Pending flag:
  - A rising edge while busy sets pending.
  - Multiple edges coalesce into one.
  - An edge in the DONE cycle counts as pending.
- Mutual exclusion: clr_valid, wr_valid and cordic_start are never high in the same cycle.
- Clearing err_timeout: only reset clears it.

Test Plan:
- Nominal frame. Stimulus: fb_ready=1, alarm_en=0, hour 0° (sin=0, cos=16384), minute 90° (sin=16384, cos=0), CORDIC model with 16-cycle latency. Required:
  - 64 clears, rows 0..63.
  - Hour: 12 writes at (32,31),(32,29)..(32,9).
  - Minute: 16 writes at (33,32)..(63,32).
  - Second hand drawn, no alarm writes, exactly one frame_done pulse.
- Backpressure: fb_ready random 50% -> wr_x/wr_y never change while wr_valid&&!fb_ready; write sequence identical to the nominal case.
- Negative and truncation: sin=cos=-11585 at r=3 -> (30,34). sin=-16384 at r=31 -> x=1.
- Timeout: cordic_done never asserted for the hour hand -> err_timeout=1 after 63 wait cycles, no hour writes, minute cordic_start pulse follows.
- Pending: three frame_req edges during PLOT -> one extra frame only, CLEAR entered the cycle after frame_done, busy never drops between frames.
- Reset mid-PLOT: all outputs 0 immediately, no further requests. A later frame_req runs a full clean frame.

Source files
------------

// File: rtl/clock_hand_sequencer.sv
// clock_hand_sequencer: per-frame scheduler that clears the framebuffer, then draws
// the hour, minute, second and alarm hands through one shared CORDIC unit.
module clock_hand_sequencer #(
    parameter int CENTER         = 32,
    parameter int HOUR_LEN       = 23,
    parameter int MIN_LEN        = 31,
    parameter int SEC_LEN        = 27,
    parameter int ALARM_LEN      = 17,
    parameter int STEP           = 2,
    parameter int CORDIC_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_req,
    input  logic [8:0]  hour_angle,
    input  logic [8:0]  minute_angle,
    input  logic [8:0]  second_angle,
    input  logic [8:0]  alarm_angle,
    input  logic        alarm_en,
    output logic        cordic_start,
    output logic [15:0] cordic_angle,
    input  logic [15:0] cordic_sin,
    input  logic [15:0] cordic_cos,
    input  logic        cordic_done,
    output logic        clr_valid,
    output logic [5:0]  clr_row,
    output logic        wr_valid,
    output logic [5:0]  wr_x,
    output logic [5:0]  wr_y,
    input  logic        fb_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout
);
    typedef enum logic [2:0] {IDLE, CLEAR, CREQ, CWAIT, PLOT, NEXT, DONE} state_t;
    state_t             state_q, state_d;
    logic               req_q, pending_q, pending_d, aen_q, aen_d, err_q, err_d;
    logic [3:0][8:0]    ang_q, ang_d;
    logic [1:0]         hand_q, hand_d;
    logic [5:0]         row_q, row_d, cnt_q, cnt_d, r_q, r_d, len;
    logic signed [15:0] sin_q, sin_d, cos_q, cos_d;
    logic signed [22:0] ps, pc;
    logic signed [7:0]  so, co, x, y;
    logic               edge_s, in_range, last;

    assign edge_s = frame_req & ~req_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            aen_q     <= 1'b0;
            err_q     <= 1'b0;
            ang_q     <= '0;
            hand_q    <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            r_q       <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= frame_req;
            pending_q <= pending_d;
            aen_q     <= aen_d;
            err_q     <= err_d;
            ang_q     <= ang_d;
            hand_q    <= hand_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
        end
    end

    // Point on the current hand; offsets truncate toward zero so both halves stay symmetric.
    always_comb begin
        len = hand_q == 2'd0 ? 6'(HOUR_LEN) : hand_q == 2'd1 ? 6'(MIN_LEN) :
              hand_q == 2'd2 ? 6'(SEC_LEN) : 6'(ALARM_LEN);
        ps = 23'(sin_q) * 23'($signed({1'b0, r_q}));
        pc = 23'(cos_q) * 23'($signed({1'b0, r_q}));
        so = 8'(ps[22] ? -((-ps) >>> 14) : ps >>> 14);
        co = 8'(pc[22] ? -((-pc) >>> 14) : pc >>> 14);
        x = 8'(CENTER) + so;
        y = 8'(CENTER) - co;
        in_range = (x[7:6] == 2'b00) && (y[7:6] == 2'b00);
        last = ({1'b0, r_q} + 7'(STEP)) > {1'b0, len};
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        aen_d     = aen_q;
        err_d     = err_q;
        ang_d     = ang_q;
        hand_d    = hand_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        if (edge_s && state_q != IDLE && state_q != DONE) pending_d = 1'b1;
        case (state_q)
            IDLE: if (edge_s) begin
                state_d = CLEAR;
                row_d   = '0;
                ang_d   = {alarm_angle, second_angle, minute_angle, hour_angle};
                aen_d   = alarm_en;
            end
            CLEAR: if (fb_ready) begin
                row_d = row_q + 6'd1;
                if (row_q == 6'd63) begin
                    state_d = CREQ;
                    hand_d  = '0;
                end
            end
            CREQ: begin
                state_d = CWAIT;
                cnt_d   = '0;
            end
            CWAIT: if (cordic_done) begin
                sin_d   = $signed(cordic_sin);
                cos_d   = $signed(cordic_cos);
                r_d     = 6'd1;
                state_d = PLOT;
            end else begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(CORDIC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            PLOT: if (!in_range || fb_ready) begin
                if (last) state_d = NEXT;
                else r_d = r_q + 6'(STEP);
            end
            NEXT: begin
                hand_d  = hand_q + 2'd1;
                state_d = (hand_q == 2'd3 || (hand_q == 2'd2 && !aen_q)) ? DONE : CREQ;
            end
            DONE: if (pending_q || edge_s) begin
                pending_d = 1'b0;
                state_d   = CLEAR;
                row_d     = '0;
                ang_d     = {alarm_angle, second_angle, minute_angle, hour_angle};
                aen_d     = alarm_en;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = state_q != IDLE;
        clr_valid    = state_q == CLEAR;
        clr_row      = row_q;
        cordic_start = state_q == CREQ;
        cordic_angle = cordic_start ? {7'd0, ang_q[hand_q]} : '0;
        wr_valid     = state_q == PLOT && in_range;
        wr_x         = wr_valid ? x[5:0] : '0;
        wr_y         = wr_valid ? y[5:0] : '0;
        frame_done   = state_q == DONE;
        err_timeout  = err_q;
    end
endmodule

// File: tb/tb_clock_hand_sequencer.sv
// tb_clock_hand_sequencer: scoreboard bench for the clock-hand frame sequencer
// with a fixed-latency CORDIC model and optional random framebuffer backpressure.
module tb_clock_hand_sequencer;
    logic        clk = 0, reset = 1, frame_req = 0, alarm_en = 0, cordic_done = 0, fb_ready = 1;
    logic [8:0]  hour_angle = 0, minute_angle = 0, second_angle = 0, alarm_angle = 0;
    logic [15:0] cordic_sin = 0, cordic_cos = 0, cordic_angle;
    logic        cordic_start, clr_valid, wr_valid, busy, frame_done, err_timeout;
    logic [5:0]  clr_row, wr_x, wr_y;

    typedef struct {int wr; int a; int b;} ev_t;
    ev_t exp_q[$];
    int  tests = 0, fails = 0;
    int  cyc = 0, done_cnt = 0, clr_cnt = 0, hold_cnt = 0, busy_falls = 0;
    int  start_cyc[$], wlog_x[$], wlog_y[$];
    bit  rnd_ready = 0, hold_prev = 0, busy_prev = 0;
    int  px = 0, py = 0;

    clock_hand_sequencer dut (
        .clk(clk), .reset(reset), .frame_req(frame_req),
        .hour_angle(hour_angle), .minute_angle(minute_angle),
        .second_angle(second_angle), .alarm_angle(alarm_angle), .alarm_en(alarm_en),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos), .cordic_done(cordic_done),
        .clr_valid(clr_valid), .clr_row(clr_row), .wr_valid(wr_valid),
        .wr_x(wr_x), .wr_y(wr_y), .fb_ready(fb_ready), .busy(busy),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Angle 45 is deliberately unanswered so a hand can be forced into timeout.
    function automatic void trig(input int ang, output int s, output int c, output bit ok);
        ok = 1;
        case (ang)
            0:       begin s = 0;      c = 16384;  end
            90:      begin s = 16384;  c = 0;      end
            180:     begin s = 0;      c = -16384; end
            270:     begin s = -16384; c = 0;      end
            225:     begin s = -11585; c = -11585; end
            default: begin s = 0;      c = 0; ok = 0; end
        endcase
    endfunction

    function automatic void push_hand(input int ang, input int len);
        int s, c, x, y;
        bit ok;
        ev_t e;
        trig(ang, s, c, ok);
        for (int r = 1; r <= len; r += 2) begin
            x = 32 + (s * r) / 16384;
            y = 32 - (c * r) / 16384;
            if (x >= 0 && x <= 63 && y >= 0 && y <= 63) begin
                e.wr = 1; e.a = x; e.b = y;
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void push_frame(input int h, m, s, a, input bit aen, input bit skip_hour);
        ev_t e;
        for (int i = 0; i < 64; i++) begin
            e.wr = 0; e.a = i; e.b = 0;
            exp_q.push_back(e);
        end
        if (!skip_hour) push_hand(h, 23);
        push_hand(m, 31);
        push_hand(s, 27);
        if (aen) push_hand(a, 17);
    endfunction

    initial forever begin
        @(posedge clk); #1;
        fb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        int ang, s, c, lat;
        bit st, ok;
        lat = 0;
        forever begin
            @(negedge clk);
            st = cordic_start;
            ang = int'(cordic_angle);
            @(posedge clk); #1;
            cordic_done = 0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) cordic_done = 1;
            end
            if (st) begin
                trig(ang, s, c, ok);
                if (ok) begin
                    cordic_sin = 16'(s);
                    cordic_cos = 16'(c);
                    lat = 16;
                end
            end
        end
    end

    // One sampled cycle: scoreboard pop on each accepted request plus cycle-level invariants.
    task automatic step();
        ev_t o, e;
        @(negedge clk);
        cyc++;
        if (cordic_start) start_cyc.push_back(cyc);
        if (frame_done) done_cnt++;
        if (busy_prev && !busy) busy_falls++;
        busy_prev = busy;
        tests++;
        if (int'(clr_valid) + int'(wr_valid) + int'(cordic_start) > 1) begin
            fails++;
            $display("FAIL mutex: clr=%0b wr=%0b start=%0b, required at most one", clr_valid, wr_valid, cordic_start);
        end
        if (hold_prev) begin
            hold_cnt++;
            tests++;
            if (!wr_valid || wr_x !== 6'(px) || wr_y !== 6'(py)) begin
                fails++;
                $display("FAIL hold: wr_valid=%0b (%0d,%0d), required 1 (%0d,%0d)", wr_valid, wr_x, wr_y, px, py);
            end
        end
        hold_prev = wr_valid && !fb_ready;
        px = int'(wr_x);
        py = int'(wr_y);
        if (fb_ready && (clr_valid || wr_valid)) begin
            o.wr = wr_valid ? 1 : 0;
            o.a = wr_valid ? int'(wr_x) : int'(clr_row);
            o.b = wr_valid ? int'(wr_y) : 0;
            if (wr_valid) begin
                wlog_x.push_back(o.a);
                wlog_y.push_back(o.b);
            end else clr_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL event: got wr=%0d a=%0d b=%0d, required nothing", o.wr, o.a, o.b);
            end else begin
                e = exp_q.pop_front();
                if (o.wr !== e.wr || o.a !== e.a || o.b !== e.b) begin
                    fails++;
                    $display("FAIL event: got wr=%0d a=%0d b=%0d, required wr=%0d a=%0d b=%0d", o.wr, o.a, o.b, e.wr, e.a, e.b);
                end
            end
        end
    endtask

    task automatic set_angles(input int h, m, s, a, input bit aen);
        hour_angle = 9'(h); minute_angle = 9'(m); second_angle = 9'(s); alarm_angle = 9'(a);
        alarm_en = aen;
    endtask

    task automatic pulse_req();
        frame_req = 1;
        step();
        frame_req = 0;
        step();
    endtask

    task automatic wait_done(input int n, input string name);
        int k = 0;
        while (done_cnt < n && k < 5000) begin
            step();
            k++;
        end
        tests++;
        if (done_cnt < n) begin
            fails++;
            $display("FAIL %s timeout: frame_done count %0d, required %0d", name, done_cnt, n);
        end
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d expected events left, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        tests++;
        if ({cordic_start, clr_valid, wr_valid, busy, frame_done, err_timeout, wr_x, wr_y, clr_row, cordic_angle} !== '0) begin
            fails++;
            $display("FAIL reset outputs: busy=%0b clr=%0b wr=%0b start=%0b done=%0b err=%0b, required all 0",
                     busy, clr_valid, wr_valid, cordic_start, frame_done, err_timeout);
        end
        reset = 0;
        repeat (2) step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset idle busy: %0b, required 0", busy);
        end
    endtask

    task automatic test_nominal();
        int d0 = done_cnt, c0 = clr_cnt;
        wlog_x.delete(); wlog_y.delete();
        set_angles(0, 90, 180, 270, 0);
        push_frame(0, 90, 180, 270, 0, 0);
        pulse_req();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL nominal busy: %0b, required 1", busy);
        end
        wait_done(d0 + 1, "nominal");
        repeat (10) step();
        check_drained("nominal");
        tests++;
        if (clr_cnt - c0 != 64) begin
            fails++;
            $display("FAIL nominal clears: %0d, required 64", clr_cnt - c0);
        end
        tests++;
        if (wlog_x.size() != 42) begin
            fails++;
            $display("FAIL nominal writes: %0d, required 42", wlog_x.size());
        end
        tests++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL nominal end: done pulses=%0d busy=%0b err=%0b, required 1 0 0", done_cnt - d0, busy, err_timeout);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt, h0 = hold_cnt;
        rnd_ready = 1;
        set_angles(0, 90, 180, 270, 0);
        push_frame(0, 90, 180, 270, 0, 0);
        pulse_req();
        wait_done(d0 + 1, "backpressure");
        rnd_ready = 0;
        repeat (10) step();
        check_drained("backpressure");
        tests++;
        if (hold_cnt == h0) begin
            fails++;
            $display("FAIL backpressure stalls: %0d stalled writes, required >0", hold_cnt - h0);
        end
    endtask

    task automatic test_negative();
        int d0 = done_cnt;
        wlog_x.delete(); wlog_y.delete();
        set_angles(225, 270, 0, 90, 1);
        push_frame(225, 270, 0, 90, 1, 0);
        pulse_req();
        wait_done(d0 + 1, "negative");
        repeat (10) step();
        check_drained("negative");
        tests++;
        if (wlog_x.size() < 28 || wlog_x[1] != 30 || wlog_y[1] != 34) begin
            fails++;
            $display("FAIL negative r3: writes=%0d point=(%0d,%0d), required (30,34)", wlog_x.size(),
                     wlog_x.size() > 1 ? wlog_x[1] : -1, wlog_y.size() > 1 ? wlog_y[1] : -1);
        end
        tests++;
        if (wlog_x.size() < 28 || wlog_x[27] != 1 || wlog_y[27] != 32) begin
            fails++;
            $display("FAIL negative r31: point=(%0d,%0d), required (1,32)",
                     wlog_x.size() > 27 ? wlog_x[27] : -1, wlog_y.size() > 27 ? wlog_y[27] : -1);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt, s0 = start_cyc.size();
        tests++;
        if (err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout pre: err=%0b, required 0", err_timeout);
        end
        set_angles(45, 90, 180, 270, 0);
        push_frame(45, 90, 180, 270, 0, 1);
        pulse_req();
        wait_done(d0 + 1, "timeout");
        repeat (10) step();
        check_drained("timeout");
        tests++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout flag: err=%0b, required 1", err_timeout);
        end
        tests++;
        if (start_cyc.size() - s0 != 3 || start_cyc[s0 + 1] - start_cyc[s0] != 65) begin
            fails++;
            $display("FAIL timeout gap: starts=%0d gap=%0d, required 3 and 65", start_cyc.size() - s0,
                     start_cyc.size() > s0 + 1 ? start_cyc[s0 + 1] - start_cyc[s0] : -1);
        end
    endtask

    task automatic test_pending();
        int d0 = done_cnt, f0 = busy_falls, k = 0;
        set_angles(0, 90, 180, 270, 0);
        push_frame(0, 90, 180, 270, 0, 0);
        push_frame(0, 90, 180, 270, 0, 0);
        pulse_req();
        while (!wr_valid && k < 2000) begin
            step();
            k++;
        end
        repeat (3) pulse_req();
        wait_done(d0 + 1, "pending first");
        step();
        tests++;
        if (clr_valid !== 1'b1 || busy !== 1'b1 || clr_row !== 6'd0) begin
            fails++;
            $display("FAIL pending restart: clr=%0b busy=%0b row=%0d, required 1 1 0", clr_valid, busy, clr_row);
        end
        wait_done(d0 + 2, "pending second");
        repeat (30) step();
        check_drained("pending");
        tests++;
        if (done_cnt - d0 != 2 || busy_falls - f0 != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pending frames: done=%0d busy_falls=%0d busy=%0b, required 2 1 0", done_cnt - d0, busy_falls - f0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0, k = 0;
        set_angles(0, 90, 180, 270, 0);
        push_frame(0, 90, 180, 270, 0, 0);
        pulse_req();
        while (!wr_valid && k < 2000) begin
            step();
            k++;
        end
        #2 reset = 1;
        #1;
        exp_q.delete();
        tests++;
        if ({cordic_start, clr_valid, wr_valid, busy, frame_done, err_timeout, wr_x, wr_y, clr_row, cordic_angle} !== '0) begin
            fails++;
            $display("FAIL reset mid: busy=%0b clr=%0b wr=%0b start=%0b done=%0b err=%0b, required all 0",
                     busy, clr_valid, wr_valid, cordic_start, frame_done, err_timeout);
        end
        repeat (5) step();
        tests++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset hold: busy=%0b wr=%0b, required 0 0", busy, wr_valid);
        end
        reset = 0;
        repeat (25) step();
        d0 = done_cnt;
        push_frame(0, 90, 180, 270, 0, 0);
        pulse_req();
        wait_done(d0 + 1, "post reset");
        repeat (10) step();
        check_drained("post reset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_negative();
        test_timeout();
        test_pending();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
